// File: rtl/tri_bus_arbiter_if.sv
// Bus bundle shared by the tristate-bus arbiter and its requesters.
// The arbiter side takes the master modport: it samples the request
// levels and drives grant, buffer enables and status back out.
interface tri_bus_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] oe;
    logic [2:0]   owner;
    logic         busy;
    logic         timeout;

    modport master (
        input  req,
        output gnt,
        output oe,
        output owner,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        input  gnt,
        input  oe,
        input  owner,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for N requesters sharing one tristate bus.
// A grant lasts while the owner holds its request, up to MAX_HOLD cycles,
// after which it is forcibly released and a timeout pulse is raised.
// Every release is followed by TA turnaround cycles with all buffers off
// so two drivers never fight on the bus. The owner's buffer enable trails
// its grant by one cycle so the requester has a setup cycle before driving.
module tri_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int TA       = 1
) (
    input  logic               clk,
    input  logic               rst,
    tri_bus_arbiter_if.master  bus
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t       state_r;
    logic [N-1:0] gnt_r;
    logic [N-1:0] oe_r;
    logic [2:0]   owner_r;
    logic [2:0]   last_owner_r;
    logic         busy_r;
    logic         timeout_r;
    logic [7:0]   hold_cnt_r;
    logic [3:0]   turn_cnt_r;

    logic [2:0]   pick_idx_s;
    logic [N-1:0] pick_onehot_s;
    logic         own_req_s;

    // First requester found searching upward from last+1 with wrap-around.
    // Walking the candidates from farthest to nearest and overwriting leaves
    // the nearest requesting index as the result.
    function automatic logic [2:0] rr_pick(input logic [N-1:0] r,
                                           input logic [2:0]   last);
        logic [2:0] idx;
        int         cand;
        idx = 3'd0;
        for (int i = N; i >= 1; i--) begin
            cand = (int'(last) + i) % N;
            if (r[IW'(cand)]) begin
                idx = 3'(cand);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next-owner selection and the current owner's request level.
    always_comb begin
        pick_idx_s    = rr_pick(bus.req, last_owner_r);
        pick_onehot_s = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
        own_req_s     = |(bus.req & gnt_r);
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            gnt_r        <= {N{1'b0}};
            oe_r         <= {N{1'b0}};
            owner_r      <= 3'd0;
            last_owner_r <= 3'(N - 1);
            busy_r       <= 1'b0;
            timeout_r    <= 1'b0;
            hold_cnt_r   <= 8'd0;
            turn_cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timeout_r <= 1'b0;
                    oe_r      <= {N{1'b0}};
                    if (bus.req != {N{1'b0}}) begin
                        state_r      <= ST_GRANT;
                        gnt_r        <= pick_onehot_s;
                        owner_r      <= pick_idx_s;
                        last_owner_r <= pick_idx_s;
                        busy_r       <= 1'b1;
                        hold_cnt_r   <= 8'd0;
                    end else begin
                        gnt_r  <= {N{1'b0}};
                        busy_r <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    if (!own_req_s) begin
                        // Voluntary release wins even when the hold limit
                        // is reached on the same edge.
                        state_r    <= ST_TURN;
                        gnt_r      <= {N{1'b0}};
                        oe_r       <= {N{1'b0}};
                        busy_r     <= 1'b0;
                        timeout_r  <= 1'b0;
                        turn_cnt_r <= 4'd0;
                    end else if (hold_cnt_r == 8'(MAX_HOLD - 1)) begin
                        state_r    <= ST_TURN;
                        gnt_r      <= {N{1'b0}};
                        oe_r       <= {N{1'b0}};
                        busy_r     <= 1'b0;
                        timeout_r  <= 1'b1;
                        turn_cnt_r <= 4'd0;
                    end else begin
                        // Buffer enable follows grant after the setup cycle.
                        oe_r       <= gnt_r;
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                        timeout_r  <= 1'b0;
                    end
                end

                ST_TURN: begin
                    timeout_r <= 1'b0;
                    gnt_r     <= {N{1'b0}};
                    oe_r      <= {N{1'b0}};
                    busy_r    <= 1'b0;
                    if (turn_cnt_r == 4'(TA - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        turn_cnt_r <= turn_cnt_r + 4'd1;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    gnt_r     <= {N{1'b0}};
                    oe_r      <= {N{1'b0}};
                    busy_r    <= 1'b0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.oe      = oe_r;
    assign bus.owner   = owner_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter with N=4, MAX_HOLD=8, TA=1.
// Each scenario pushes the expected per-cycle outputs into a queue and
// pops them as the design produces them; a monitor checks the one-hot
// and enable-within-grant properties every cycle.
module tb_tri_bus_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tri_bus_arbiter_if #(.N(4)) bus ();

    tri_bus_arbiter #(
        .N        (4),
        .MAX_HOLD (8),
        .TA       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {gnt, oe, owner, busy, timeout}
    logic [12:0] obs;
    logic [12:0] exp_q[$];
    logic [12:0] exp_v;

    assign obs = {bus.gnt, bus.oe, bus.owner, bus.busy, bus.timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic [3:0] g, input logic [3:0] o,
                                       input logic [2:0] ow, input logic b,
                                       input logic t);
        return {g, o, ow, b, t};
    endfunction

    // Push one full grant: first cycle without oe, then oe on, for n cycles.
    task automatic push_grant(input int idx, input int n);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        exp_q.push_back(pk(oh, 4'b0000, 3'(idx), 1'b1, 1'b0));
        for (int k = 1; k < n; k++) exp_q.push_back(pk(oh, oh, 3'(idx), 1'b1, 1'b0));
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
    endtask

    // Every-cycle structural checks on grant and enable.
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (!$onehot0(bus.gnt) || !$onehot0(bus.oe) || ((bus.oe & ~bus.gnt) != 4'b0000)) begin
                bad++;
                $display("FAIL onehot gnt=%b oe=%b (need one-hot, oe within gnt)", bus.gnt, bus.oe);
            end
        end
    end

    task automatic test_reset();
        rst     = 1'b0;
        bus.req = 4'b1111;
        #3;
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
        do_reset();
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0));
        for (int c = 0; c < 1; c++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_idle c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_single_release();
        do_reset();
        bus.req = 4'b0100;
        push_grant(2, 4);
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd2, 1'b0, 1'b0));
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd2, 1'b0, 1'b0));
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd2, 1'b0, 1'b0));
        for (int c = 0; c < 7; c++) begin
            if (c == 4) bus.req = 4'b0000;
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL single c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_grant(k % 4, 8);
            exp_q.push_back(pk(4'b0000, 4'b0000, 3'(k % 4), 1'b0, 1'b1));
            exp_q.push_back(pk(4'b0000, 4'b0000, 3'(k % 4), 1'b0, 1'b0));
        end
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL rotate c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_solo_timeout();
        do_reset();
        bus.req = 4'b0010;
        push_grant(1, 8);
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd1, 1'b0, 1'b1));
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd1, 1'b0, 1'b0));
        push_grant(1, 2);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL solo c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_drop_at_limit();
        do_reset();
        bus.req = 4'b1000;
        push_grant(3, 8);
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd3, 1'b0, 1'b0));
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd3, 1'b0, 1'b0));
        for (int c = 0; c < 10; c++) begin
            if (c == 8) bus.req = 4'b0000;
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL drop_limit c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0001;
        push_grant(0, 3);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL areset_pre c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
        // Mid-grant, between edges: outputs must clear without a clock.
        rst     = 1'b0;
        bus.req = 4'b1111;
        #2;
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0));
        exp_v = exp_q.pop_front();
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL areset_async got=%b want=%b", obs, exp_v);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        push_grant(0, 1);
        for (int c = 0; c < 1; c++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL areset_first c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_turn_request();
        do_reset();
        bus.req = 4'b0001;
        push_grant(0, 2);
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(pk(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0));
        push_grant(2, 2);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) bus.req = 4'b0000;
            if (c == 3) bus.req = 4'b0100;
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL turn_req c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        bus.req = 4'b0000;
        test_reset();
        test_single_release();
        test_back_to_back();
        test_solo_timeout();
        test_drop_at_limit();
        test_async_reset();
        test_turn_request();
        bus.req = 4'b0000;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
